// File: rtl/cvxif_mac_coprocessor.sv
// cvxif_mac_coprocessor: CV-X-IF responder that executes custom-0 int8
// dot-product / accumulate instructions (MAC4, CLRACC, RELU).
// Speculatively issued instructions wait in an in-order queue until they are
// committed or killed. Results leave through a registered channel in commit order.
// Optional feature macro: CVXIF_MAC_SAT_EN. When it is defined, the MAC4
// accumulate saturates on signed overflow. When it is undefined, the accumulate
// wraps modulo 2^32.
module cvxif_mac_coprocessor #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  input  logic [1:0]      issue_rs_valid_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic [XLEN-1:0] result_data_o,
  output logic            result_we_o
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_ISSUED, ST_COMMITTED, ST_KILLED} entry_state_t;

  // Queue storage: payload arrays have no reset; only the entry states do.
  logic [ID_W-1:0] id_mem  [DEPTH];
  logic [2:0]      f3_mem  [DEPTH];
  logic [4:0]      rd_mem  [DEPTH];
  logic [XLEN-1:0] rs1_mem [DEPTH];
  logic [XLEN-1:0] rs2_mem [DEPTH];
  entry_state_t    st_mem  [DEPTH];

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg;
  logic [31:0]      acc_reg;

  logic            result_valid_reg;
  logic [ID_W-1:0] result_id_reg;
  logic [4:0]      result_rd_reg;
  logic [XLEN-1:0] result_data_reg;

  // Decode: instruction bits above funct3 carry no meaning for this unit.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, issue_instr_i[31:15]};

  logic claimed, push;
  assign claimed = (issue_instr_i[6:0] == 7'b0001011) &&
                   (issue_instr_i[14:12] inside {3'b000, 3'b001, 3'b010}) &&
                   (issue_rs_valid_i == 2'b11);
  assign issue_ready_o     = (count_reg != (PTR_W+1)'(DEPTH));
  assign issue_accept_o    = issue_valid_i & claimed;
  assign issue_writeback_o = issue_accept_o;
  assign push              = issue_valid_i & issue_ready_o & claimed;

  // Per-slot commit candidates: occupied, still ISSUED, and carrying the committed id.
  logic [DEPTH-1:0] slot_match;
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] offset;
    assign offset = PTR_W'(gi) - head_reg;
    assign slot_match[gi] = ({1'b0, offset} < count_reg) &&
                            (st_mem[gi] == ST_ISSUED) && (id_mem[gi] == commit_id_i);
  end

  logic             cm_hit;
  logic [PTR_W-1:0] cm_slot, scan_slot;
  // Pick the oldest matching entry by walking from the head.
  always_comb begin
    cm_hit    = 1'b0;
    cm_slot   = '0;
    scan_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_slot = head_reg + PTR_W'(k);
      if (!cm_hit && slot_match[scan_slot]) begin
        cm_hit  = 1'b1;
        cm_slot = scan_slot;
      end
    end
  end

  // A commit that finds no queued entry lands on the instruction being pushed now.
  logic commit_new;
  assign commit_new = commit_valid_i & push & ~cm_hit & (issue_id_i == commit_id_i);

  // Execute stage looks only at the head entry.
  logic            empty, slot_free, pop_kill, pop_exec, pop;
  entry_state_t    head_st;
  logic [2:0]      head_f3;
  logic [XLEN-1:0] head_rs1, head_rs2;
  assign empty     = (count_reg == '0);
  assign head_st   = st_mem[head_reg];
  assign head_f3   = f3_mem[head_reg];
  assign head_rs1  = rs1_mem[head_reg];
  assign head_rs2  = rs2_mem[head_reg];
  assign slot_free = ~result_valid_reg | result_ready_i;
  assign pop_kill  = ~empty & (head_st == ST_KILLED);
  assign pop_exec  = ~empty & (head_st == ST_COMMITTED) & slot_free;
  assign pop       = pop_kill | pop_exec;

  logic signed [15:0] a16, b16, p16;
  logic [31:0]        dot, mac_acc, res_data, acc_next;
`ifdef CVXIF_MAC_SAT_EN
  logic [32:0]        acc_sum;
`else
  logic [31:0]        acc_sum;
`endif
  // Signed int8 dot product, accumulate, and per-opcode result selection.
  always_comb begin
    a16 = '0;
    b16 = '0;
    p16 = '0;
    dot = '0;
    for (int k = 0; k < 4; k++) begin
      a16 = {{8{head_rs1[8*k+7]}}, head_rs1[8*k +: 8]};
      b16 = {{8{head_rs2[8*k+7]}}, head_rs2[8*k +: 8]};
      p16 = a16 * b16;
      dot = dot + {{16{p16[15]}}, p16};
    end
`ifdef CVXIF_MAC_SAT_EN
    acc_sum = {acc_reg[31], acc_reg} + {dot[31], dot};
    if (acc_sum[32] != acc_sum[31])
      mac_acc = acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      mac_acc = acc_sum[31:0];
`else
    acc_sum = acc_reg + dot;
    mac_acc = acc_sum;
`endif
    res_data = '0;
    acc_next = acc_reg;
    case (head_f3)
      3'b000:  begin res_data = mac_acc; acc_next = mac_acc; end
      3'b001:  begin res_data = acc_reg; acc_next = '0; end
      3'b010:  res_data = head_rs1[31] ? '0 : head_rs1;
      default: ;
    endcase
  end

  // Queue pointers, occupancy and the accumulator.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      acc_reg   <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_reg + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      if (pop_exec) acc_reg <= acc_next;
    end
  end

  // Entry states: set on push, advanced by commit or kill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) st_mem[k] <= ST_ISSUED;
    end else begin
      if (push)
        st_mem[tail_reg] <= commit_new ? (commit_kill_i ? ST_KILLED : ST_COMMITTED) : ST_ISSUED;
      if (commit_valid_i && cm_hit)
        st_mem[cm_slot] <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
    end
  end

  // Payload capture on an accepted issue.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[tail_reg]  <= issue_id_i;
      f3_mem[tail_reg]  <= issue_instr_i[14:12];
      rd_mem[tail_reg]  <= issue_instr_i[11:7];
      rs1_mem[tail_reg] <= issue_rs1_i;
      rs2_mem[tail_reg] <= issue_rs2_i;
    end
  end

  // Result register: loads on execute, holds while stalled, clears once consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_valid_reg <= 1'b0;
      result_id_reg    <= '0;
      result_rd_reg    <= '0;
      result_data_reg  <= '0;
    end else if (pop_exec) begin
      result_valid_reg <= 1'b1;
      result_id_reg    <= id_mem[head_reg];
      result_rd_reg    <= rd_mem[head_reg];
      result_data_reg  <= res_data;
    end else if (result_ready_i) begin
      result_valid_reg <= 1'b0;
    end
  end

  assign result_valid_o = result_valid_reg;
  assign result_we_o    = result_valid_reg;
  assign result_id_o    = result_id_reg;
  assign result_rd_o    = result_rd_reg;
  assign result_data_o  = result_data_reg;
endmodule

// File: tb/tb_cvxif_mac_coprocessor.sv
// Testbench for cvxif_mac_coprocessor: directed stimulus with a result scoreboard.
module tb_cvxif_mac_coprocessor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [31:0] issue_instr = '0;
  logic [3:0]  issue_id = '0;
  logic [31:0] issue_rs1 = '0;
  logic [31:0] issue_rs2 = '0;
  logic [1:0]  issue_rs_valid = 2'b11;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        commit_kill = 1'b0;
  logic        result_ready = 1'b1;
  logic        issue_ready_o, issue_accept_o, issue_writeback_o;
  logic        result_valid_o, result_we_o;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  cvxif_mac_coprocessor #(.ID_W(4), .DEPTH(4), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr), .issue_id_i(issue_id),
    .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_rs_valid_i(issue_rs_valid),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_data_o(result_data_o), .result_we_o(result_we_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {17'b0, f3, rd, 7'b0001011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.id = id;
    e.rd = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // One issue transaction; optionally commits the same id in the same cycle.
  task automatic do_issue(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic cmt, input logic exp_acc);
    int n = 0;
    while (!issue_ready_o && n < 50) begin tick(); n++; end
    if (!issue_ready_o) begin
      checks++; failures++;
      $display("FAIL issue_ready_timeout actual=0 required=1");
    end
    issue_valid = 1'b1; issue_instr = instr; issue_id = id; issue_rs1 = rs1; issue_rs2 = rs2;
    if (cmt) begin commit_valid = 1'b1; commit_id = id; commit_kill = 1'b0; end
    #1;
    chk1("issue_accept", issue_accept_o, exp_acc);
    chk1("issue_writeback", issue_writeback_o, exp_acc);
    tick();
    issue_valid = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || result_valid_o) && n < 300) begin tick(); n++; end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every consumed result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && result_valid_o && result_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result id=%0d data=%h required=none", result_id_o, result_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("result_id", {28'b0, result_id_o}, {28'b0, mon_e.id});
        chk("result_rd", {27'b0, result_rd_o}, {27'b0, mon_e.rd});
        chk("result_data", result_data_o, mon_e.data);
        chk1("result_we", result_we_o, 1'b1);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_issue_ready", issue_ready_o, 1'b1);
    chk1("rst_result_valid", result_valid_o, 1'b0);
    chk1("rst_result_we", result_we_o, 1'b0);
    chk("rst_result_data", result_data_o, 32'd0);
    rst = 1'b0;
    tick();
    chk1("idle_result_valid", result_valid_o, 1'b0);

    // MAC4 basic: 1+2+3+4 = 10, then -10 brings ACC back to 0
    push_exp(4'd0, 5'd5, 32'd10);
    do_issue(mk(3'b000, 5'd5), 4'd0, 32'h01020304, 32'h01010101, 1'b1, 1'b1);
    push_exp(4'd1, 5'd6, 32'd0);
    do_issue(mk(3'b000, 5'd6), 4'd1, 32'h01020304, 32'hFFFFFFFF, 1'b1, 1'b1);
    drain();

    // Killed MAC4 must not touch ACC or produce a result
    do_issue(mk(3'b000, 5'd7), 4'd1, 32'h02020202, 32'h02020202, 1'b0, 1'b1);
    do_commit(4'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("killed_no_result", result_valid_o, 1'b0);
      tick();
    end
    push_exp(4'd2, 5'd8, 32'd10);
    do_issue(mk(3'b000, 5'd8), 4'd2, 32'h01020304, 32'h01010101, 1'b1, 1'b1);
    push_exp(4'd3, 5'd9, 32'd10);
    do_issue(mk(3'b001, 5'd9), 4'd3, 32'h0, 32'h0, 1'b1, 1'b1);
    push_exp(4'd4, 5'd10, 32'd0);
    do_issue(mk(3'b001, 5'd10), 4'd4, 32'h0, 32'h0, 1'b1, 1'b1);
    drain();

    // Unclaimed instructions: wrong opcode, reserved funct3, missing operand
    do_issue(32'h00000033, 4'd2, 32'h1, 32'h1, 1'b0, 1'b0);
    chk1("unclaimed_ready", issue_ready_o, 1'b1);
    do_issue(mk(3'b011, 5'd1), 4'd2, 32'h1, 32'h1, 1'b0, 1'b0);
    issue_rs_valid = 2'b01;
    do_issue(mk(3'b000, 5'd1), 4'd2, 32'h1, 32'h1, 1'b0, 1'b0);
    issue_rs_valid = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    chk1("unclaimed_no_result", result_valid_o, 1'b0);

    // Fill the queue, then commit with the result channel stalled
    result_ready = 1'b0;
    push_exp(4'd5, 5'd11, 32'h00000011);
    do_issue(mk(3'b010, 5'd11), 4'd5, 32'h00000011, 32'h0, 1'b0, 1'b1);
    push_exp(4'd6, 5'd12, 32'd10);
    do_issue(mk(3'b000, 5'd12), 4'd6, 32'h01020304, 32'h01010101, 1'b0, 1'b1);
    push_exp(4'd7, 5'd13, 32'h7FFFFFFF);
    do_issue(mk(3'b010, 5'd13), 4'd7, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1);
    push_exp(4'd8, 5'd14, 32'd10);
    do_issue(mk(3'b001, 5'd14), 4'd8, 32'h0, 32'h0, 1'b0, 1'b1);
    chk1("full_ready", issue_ready_o, 1'b0);
    do_commit(4'd5, 1'b0);
    chk1("full_pop_ready", issue_ready_o, 1'b0);
    do_commit(4'd6, 1'b0);
    do_commit(4'd7, 1'b0);
    do_commit(4'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk1("hold_valid", result_valid_o, 1'b1);
      chk("hold_id", {28'b0, result_id_o}, 32'd5);
      chk("hold_data", result_data_o, 32'h00000011);
      tick();
    end
    result_ready = 1'b1;
    drain();

    // Build ACC = 0x7FFFFFF0: 32767 x 0x10000, then 0xFC04, then 0x3EC
    for (int k = 0; k < 32767; k++) begin
      push_exp(4'(k), 5'd1, 32'(k + 1) << 16);
      do_issue(mk(3'b000, 5'd1), 4'(k), 32'h80808080, 32'h80808080, 1'b1, 1'b1);
    end
    push_exp(4'd3, 5'd2, 32'h7FFFFC04);
    do_issue(mk(3'b000, 5'd2), 4'd3, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b1);
    push_exp(4'd4, 5'd3, 32'h7FFFFFF0);
    do_issue(mk(3'b000, 5'd3), 4'd4, 32'h00000C1F, 32'h00000120, 1'b1, 1'b1);
`ifdef CVXIF_MAC_SAT_EN
    push_exp(4'd5, 5'd4, 32'h7FFFFFFF);
    push_exp(4'd6, 5'd5, 32'h7FFFFFFF);
`else
    push_exp(4'd5, 5'd4, 32'h8000FBF4);
    push_exp(4'd6, 5'd5, 32'h8000FBF4);
`endif
    do_issue(mk(3'b000, 5'd4), 4'd5, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b1);
    do_issue(mk(3'b001, 5'd5), 4'd6, 32'h0, 32'h0, 1'b1, 1'b1);
    drain();

    // RELU of a negative value with same-cycle issue and commit
    push_exp(4'd9, 5'd20, 32'd0);
    do_issue(mk(3'b010, 5'd20), 4'd9, 32'h80000005, 32'h0, 1'b1, 1'b1);
    chk1("relu_valid_early", result_valid_o, 1'b0);
    tick();
    chk1("relu_valid_rise", result_valid_o, 1'b1);
    chk("relu_data", result_data_o, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
